// File: rtl/fetch_unit_32.sv
// -----------------------------------------------------------------------------
// fetch_unit_32
//
// Purpose:
//   Instruction fetch and next-PC sequencer for the 32-bit MIPS core. Owns the
//   program counter and fetches each instruction over a req/ack handshake into
//   an instruction register that feeds the control decoder. While the
//   instruction executes, the decoder's branch/jump/illegal outputs, the ALU
//   zero flag and the jr register value select the next PC.
//
// Configuration macro:
//   FETCH_TRAP_EN - when defined, illegal opcodes, invalid jumps and misaligned
//                   targets halt the unit with a sticky error code. When
//                   undefined, such instructions retire normally: illegal
//                   opcodes and invalid jumps fall through to pc+4, and
//                   misaligned targets have their low two bits cleared.
//
// Ports:
//   clk                 in   rising-edge clock
//   rst_n               in   synchronous active-low reset
//   imem_req            out  fetch request, high only while fetching
//   imem_addr[31:0]     out  fetch address (equals pc)
//   imem_rdata[31:0]    in   instruction word, valid while imem_ack is high
//   imem_ack            in   memory completion strobe
//   branch[1:0]         in   decoder: 10 beq, 11 bne, 0x none
//   jump[1:0]           in   decoder: 00 none, 01 j/jal, 10 jr, 11 invalid
//   err_illegal_opcode  in   decoder illegal-opcode flag
//   alu_zero            in   ALU zero flag of the current instruction
//   jr_target[31:0]     in   rs value used by jr
//   stall               in   hold the current instruction in execute
//   instr[31:0]         out  instruction register
//   opcode[5:0]         out  instr[31:26]
//   funct[5:0]          out  instr[5:0]
//   pc[31:0]            out  address of the current instruction
//   pc_plus4[31:0]      out  pc + 4 (jal link value)
//   instr_valid         out  high while executing
//   instr_retire        out  one-cycle pulse when execution completes
//   halted              out  sticky halt flag
//   err_code[1:0]       out  sticky: 00 none, 01 illegal, 10 bad jump,
//                            11 misaligned target
// -----------------------------------------------------------------------------
module fetch_unit_32 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic [1:0]  branch,
    input  logic [1:0]  jump,
    input  logic        err_illegal_opcode,
    input  logic        alu_zero,
    input  logic [31:0] jr_target,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        instr_retire,
    output logic        halted,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        halted_q, halted_d;
    logic [1:0]  err_q, err_d;

    logic [31:0] seq_pc;
    logic [31:0] branch_off;
    logic        branch_taken;
    logic [31:0] raw_target;
    logic [31:0] next_pc;
    logic [1:0]  trap_code;
    logic        trap;
    logic        exec_done;

    // Sequential PC and sign-extended word offset of the branch immediate.
    // Both wrap modulo 2^32 by construction of the 32-bit adders.
    assign seq_pc       = pc_q + 32'd4;
    assign branch_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign branch_taken = branch[1] && (branch[0] ? !alu_zero : alu_zero);

    // Candidate target before any trap or alignment handling. Jumps win over
    // branches; an invalid jump encoding falls through to the branch/sequential
    // choice here and is dealt with by the trap logic below.
    always_comb begin
        raw_target = seq_pc;
        if (jump == 2'b01) begin
            raw_target = {seq_pc[31:28], instr_q[25:0], 2'b00};
        end else if (jump == 2'b10) begin
            raw_target = jr_target;
        end else if (branch_taken) begin
            raw_target = seq_pc + branch_off;
        end
    end

`ifdef FETCH_TRAP_EN
    // Trap classification; earlier checks take priority over later ones.
    always_comb begin
        trap_code = 2'b00;
        if (err_illegal_opcode) begin
            trap_code = 2'b01;
        end else if (jump == 2'b11) begin
            trap_code = 2'b10;
        end else if (raw_target[1:0] != 2'b00) begin
            trap_code = 2'b11;
        end
    end

    assign trap    = (trap_code != 2'b00);
    assign next_pc = raw_target;
`else
    // Without traps, bad instructions simply fall through to the next word and
    // any target is forced onto a word boundary.
    assign trap_code = 2'b00;
    assign trap      = 1'b0;
    assign next_pc   = (err_illegal_opcode || (jump == 2'b11)) ? seq_pc
                                                               : {raw_target[31:2], 2'b00};
`endif

    // An instruction completes in the first execute cycle without a stall.
    assign exec_done = (state_q == ST_EXEC) && !stall;

    // Next-state logic: IDLE -> FETCH -> EXEC -> FETCH ..., with HALT absorbing.
    // The ack is only looked at while fetching, so stray strobes are harmless.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        halted_d = halted_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    if (trap) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                        err_d    = trap_code;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset back to IDLE at RESET_PC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            halted_q <= 1'b0;
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    // The request and retire strobes are masked by reset so an in-flight fetch
    // is dropped and no write is enabled in the reset cycle itself.
    assign imem_req     = (state_q == ST_FETCH) && rst_n;
    assign imem_addr    = pc_q;
    assign instr        = instr_q;
    assign opcode       = instr_q[31:26];
    assign funct        = instr_q[5:0];
    assign pc           = pc_q;
    assign pc_plus4     = seq_pc;
    assign instr_valid  = (state_q == ST_EXEC);
    assign instr_retire = exec_done && !trap && rst_n;
    assign halted       = halted_q;
    assign err_code     = err_q;

endmodule

// File: tb/tb_fetch_unit_32.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit_32
//
// Self-checking bench for fetch_unit_32. A driver plays instruction memory and
// the decoder; for every instruction it predicts the fetch address and the
// retire record from an arithmetic model and pushes them into queues. A
// monitor on the falling edge pops and compares whenever the unit requests a
// fetch or retires an instruction. Honours FETCH_TRAP_EN like the design.
// -----------------------------------------------------------------------------
module tb_fetch_unit_32;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [1:0]  branch;
    logic [1:0]  jump;
    logic        err_illegal_opcode;
    logic        alu_zero;
    logic [31:0] jr_target;
    logic        stall;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_retire;
    logic        halted;
    logic [1:0]  err_code;

    fetch_unit_32 #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .imem_ack          (imem_ack),
        .branch            (branch),
        .jump              (jump),
        .err_illegal_opcode(err_illegal_opcode),
        .alu_zero          (alu_zero),
        .jr_target         (jr_target),
        .stall             (stall),
        .instr             (instr),
        .opcode            (opcode),
        .funct             (funct),
        .pc                (pc),
        .pc_plus4          (pc_plus4),
        .instr_valid       (instr_valid),
        .instr_retire      (instr_retire),
        .halted            (halted),
        .err_code          (err_code)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] word;
    } retire_t;

    int          checks = 0;
    int          failures = 0;
    int          cycleCount = 0;
    logic [31:0] fetchQ[$];
    retire_t     retireQ[$];
    logic [31:0] modelPc;
    logic [31:0] curFetch = 32'd0;
    logic        reqPrev = 1'b0;

    // 10 ns clock and a free-running cycle counter for latency checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycleCount++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: next PC and trap code from the instruction's semantics.
    function automatic void predict(input logic [31:0] curPc, input logic [31:0] word,
                                    input logic [1:0] br, input logic [1:0] jp,
                                    input logic ill, input logic zero,
                                    input logic [31:0] jrT,
                                    output logic [31:0] nextPc,
                                    output logic [1:0] trapCode);
        logic [31:0] seq;
        logic [31:0] target;
        int          offset;
        logic        taken;
        seq    = curPc + 32'd4;
        offset = int'($signed(word[15:0])) * 4;
        taken  = (br == 2'b10 && zero) || (br == 2'b11 && !zero);
        if (jp == 2'b01)
            target = (seq & 32'hF000_0000) | ({6'd0, word[25:0]} << 2);
        else if (jp == 2'b10)
            target = jrT;
        else if (taken)
            target = seq + 32'(offset);
        else
            target = seq;
        trapCode = 2'b00;
`ifdef FETCH_TRAP_EN
        if (ill)                     trapCode = 2'b01;
        else if (jp == 2'b11)        trapCode = 2'b10;
        else if (target % 4 != 0)    trapCode = 2'b11;
        nextPc = target;
`else
        if (ill || jp == 2'b11) nextPc = seq;
        else                    nextPc = target & 32'hFFFF_FFFC;
`endif
    endfunction

    // Reset sequence; optionally keeps acking junk during reset to show the
    // strobe is ignored. Leaves the unit in its first fetch cycle.
    task automatic resetDut(input logic ackDuring);
        rst_n      = 1'b0;
        imem_ack   = ackDuring;
        imem_rdata = 32'hDEAD_BEEF;
        stall      = 1'b0;
        #1;
        checkOutput("req_dropped_in_reset", {31'd0, imem_req}, 32'd0);
        waitCycle();
        waitCycle();
        fetchQ.delete();
        retireQ.delete();
        modelPc = RESET_PC;
        checkOutput("reset_pc", pc, RESET_PC);
        checkOutput("reset_imem_addr", imem_addr, RESET_PC);
        checkOutput("reset_pc_plus4", pc_plus4, RESET_PC + 32'd4);
        checkOutput("reset_instr", instr, 32'd0);
        checkOutput("reset_opcode", {26'd0, opcode}, 32'd0);
        checkOutput("reset_funct", {26'd0, funct}, 32'd0);
        checkOutput("reset_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("reset_retire", {31'd0, instr_retire}, 32'd0);
        checkOutput("reset_halted", {31'd0, halted}, 32'd0);
        checkOutput("reset_err", {30'd0, err_code}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("idle_no_req", {31'd0, imem_req}, 32'd0);
        waitCycle();
        checkOutput("first_req", {31'd0, imem_req}, 32'd1);
        checkOutput("instr_after_reset", instr, 32'd0);
        imem_ack = 1'b0;
    endtask

    // Runs one instruction through fetch and execute, queueing expectations.
    task automatic applyStimulus(input logic [31:0] word, input int waits, input int stalls,
                                 input logic [1:0] br, input logic [1:0] jp, input logic ill,
                                 input logic zero, input logic [31:0] jrT,
                                 output logic trapped);
        logic [31:0] nextPc;
        logic [1:0]  trapCode;
        int          guard;
        predict(modelPc, word, br, jp, ill, zero, jrT, nextPc, trapCode);
        fetchQ.push_back(modelPc);
        imem_ack = 1'b0;
        guard = 0;
        while (imem_req !== 1'b1 && guard < 20) begin
            waitCycle();
            guard++;
        end
        if (imem_req !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL fetch_timeout: got no request, expected imem_req within 20 cycles");
            trapped = 1'b1;
            return;
        end
        for (int w = 0; w < waits; w++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            waitCycle();
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        waitCycle();
        branch             = br;
        jump               = jp;
        err_illegal_opcode = ill;
        alu_zero           = zero;
        jr_target          = jrT;
        if (trapCode == 2'b00) retireQ.push_back('{addr: modelPc, word: word});
        for (int s = 0; s < stalls; s++) begin
            stall      = 1'b1;
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            waitCycle();
        end
        stall      = 1'b0;
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        waitCycle();
        imem_ack           = 1'b0;
        branch             = 2'b00;
        jump               = 2'b00;
        err_illegal_opcode = 1'b0;
        if (trapCode != 2'b00) begin
            checkOutput("trap_halted", {31'd0, halted}, 32'd1);
            checkOutput("trap_err_code", {30'd0, err_code}, {30'd0, trapCode});
            checkOutput("trap_pc_kept", pc, modelPc);
            for (int k = 0; k < 3; k++) begin
                checkOutput("halt_no_req", {31'd0, imem_req}, 32'd0);
                waitCycle();
            end
            trapped = 1'b1;
        end else begin
            modelPc = nextPc;
            trapped = 1'b0;
        end
    endtask

    // Monitor: pops the fetch queue on each new request and the retire queue
    // on each retire pulse, comparing against the unit's outputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            reqPrev = 1'b0;
        end else begin
            if (imem_req) begin
                if (!reqPrev) begin
                    if (fetchQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_fetch: got request at %h, expected none", imem_addr);
                    end else begin
                        curFetch = fetchQ.pop_front();
                    end
                end
                checkOutput("imem_addr", imem_addr, curFetch);
            end
            if (instr_retire) begin
                if (retireQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_retire: got retire at pc %h, expected none", pc);
                end else begin
                    retire_t r;
                    r = retireQ.pop_front();
                    checkOutput("retire_pc", pc, r.addr);
                    checkOutput("retire_instr", instr, r.word);
                    checkOutput("retire_pc_plus4", pc_plus4, r.addr + 32'd4);
                    checkOutput("retire_opcode", {26'd0, opcode}, {26'd0, r.word[31:26]});
                    checkOutput("retire_funct", {26'd0, funct}, {26'd0, r.word[5:0]});
                    checkOutput("retire_halted", {31'd0, halted}, 32'd0);
                end
            end
            reqPrev = imem_req;
        end
    end

    // Main stimulus: directed scenarios followed by a randomized stream.
    initial begin
        logic        trapped;
        int          startCycle;
        logic [31:0] word;
        logic [1:0]  br;
        logic [1:0]  jp;
        logic [31:0] jrT;
        int          sel;

        rst_n              = 1'b0;
        imem_ack           = 1'b0;
        imem_rdata         = 32'd0;
        branch             = 2'b00;
        jump               = 2'b00;
        err_illegal_opcode = 1'b0;
        alu_zero           = 1'b0;
        jr_target          = 32'd0;
        stall              = 1'b0;
        modelPc            = RESET_PC;

        resetDut(1'b0);

        // Zero-wait NOP stream: two cycles per instruction.
        startCycle = cycleCount;
        for (int i = 0; i < 4; i++)
            applyStimulus(32'd0, 0, 0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, trapped);
        checkOutput("zero_wait_cycles", 32'(cycleCount - startCycle), 32'd8);

        // Three wait states plus two stalled execute cycles.
        startCycle = cycleCount;
        applyStimulus(32'h0000_0020, 3, 2, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, trapped);
        checkOutput("wait_stall_cycles", 32'(cycleCount - startCycle), 32'd7);

        // Branch and jump targets around pc 0x100.
        applyStimulus(32'h0800_0040, 0, 0, 2'b00, 2'b01, 1'b0, 1'b0, 32'd0, trapped);
        checkOutput("j_to_0x100", modelPc, 32'h0000_0100);
        applyStimulus(32'h1000_FFFF, 0, 0, 2'b10, 2'b00, 1'b0, 1'b1, 32'd0, trapped);
        applyStimulus(32'h1400_FFFF, 1, 0, 2'b11, 2'b00, 1'b0, 1'b1, 32'd0, trapped);
        applyStimulus(32'h0000_0008, 0, 1, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0000_2000, trapped);
        // Jump beats a taken branch.
        applyStimulus(32'h0800_0080, 0, 0, 2'b10, 2'b01, 1'b0, 1'b1, 32'd0, trapped);
        // Wrap from the top of the address space.
        applyStimulus(32'h0000_0008, 0, 0, 2'b00, 2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC, trapped);
        applyStimulus(32'd0, 0, 0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, trapped);

        // Misaligned jr, invalid jump and illegal opcode.
        applyStimulus(32'h0000_0008, 0, 0, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0000_2002, trapped);
        if (trapped) resetDut(1'b0);
        applyStimulus(32'h0000_0000, 0, 0, 2'b10, 2'b11, 1'b0, 1'b1, 32'd0, trapped);
        if (trapped) resetDut(1'b0);
        applyStimulus(32'hFC00_0000, 2, 1, 2'b00, 2'b00, 1'b1, 1'b0, 32'd0, trapped);
        if (trapped) resetDut(1'b0);

        // Reset while a fetch is outstanding, with acks during reset.
        applyStimulus(32'h0000_0004, 0, 0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0, trapped);
        resetDut(1'b1);

        // Randomized instruction stream.
        for (int i = 0; i < 200; i++) begin
            word = $urandom;
            sel  = int'($urandom_range(0, 31));
            jp   = (sel < 4) ? 2'b01 : (sel < 8) ? 2'b10 : (sel == 31) ? 2'b11 : 2'b00;
            br   = 2'($urandom);
            jrT  = $urandom;
            if ($urandom_range(0, 3) != 0) jrT[1:0] = 2'b00;
            applyStimulus(word, int'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                          br, jp, 1'($urandom_range(0, 31) == 0), 1'($urandom), jrT, trapped);
            if (trapped) resetDut(1'b0);
        end

        // The final predicted PC must show up as the next fetch address.
        fetchQ.push_back(modelPc);
        @(negedge clk);
        #1;
        checkOutput("fetch_queue_drained", 32'(fetchQ.size()), 32'd0);
        checkOutput("retire_queue_drained", 32'(retireQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        failures++;
        $display("[TB] FAIL watchdog: got no completion, expected finish within 500000 ns");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit_32.md
# fetch_unit_32

Instruction fetch and next-PC sequencer for the 32-bit MIPS core. Owns the program counter, requests instructions from instruction memory over a req/ack handshake, and holds the fetched word in an instruction register. The register drives `opcode`/`funct` into the control decoder. While an instruction is executing, the block consumes the decoder's `branch`/`jump`/`err_illegal_opcode` outputs and the ALU zero flag, and selects the next PC.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports (clock/reset: one clock `clk`; reset `rst_n` is synchronous, active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous active-low reset
- `imem_req`  out  1  fetch request; high only in FETCH
- `imem_addr`  out  32  fetch address (= `pc`)
- `imem_rdata`  in  32  instruction word; valid in the cycle `imem_ack` is high
- `imem_ack`  in  1  memory completion strobe
- `branch`  in  2  from decoder: 2'b10 beq, 2'b11 bne, 2'b00 none
- `jump`  in  2  from decoder: 00 none, 01 j/jal, 10 jr, 11 invalid
- `err_illegal_opcode`  in  1  from decoder
- `alu_zero`  in  1  ALU zero flag for the current instruction
- `jr_target`  in  32  rs register value for jr
- `stall`  in  1  hold the current instruction in EXEC (data memory busy)
- `instr`  out  32  instruction register
- `opcode`  out  6  `instr[31:26]`
- `funct`  out  6  `instr[5:0]`
- `pc`  out  32  address of the current instruction
- `pc_plus4`  out  32  `pc + 4`, the jal link value
- `instr_valid`  out  1  high in EXEC
- `instr_retire`  out  1  one-cycle pulse when EXEC completes; gates register-file and data-memory writes
- `halted`  out  1  sticky; high in HALT
- `err_code`  out  2  sticky: 00 none, 01 illegal opcode, 10 invalid jump, 11 misaligned target

## Operation
- **States:**
  - IDLE: reset state, lasts 1 cycle, then goes to FETCH.
  - FETCH: `imem_req`=1, `imem_addr`=`pc` held stable. On `imem_ack`, latch `instr`<=`imem_rdata` and go to EXEC.
  - EXEC: `instr_valid`=1. If `stall`, stay in EXEC. Otherwise, if there is a trap, go to HALT. Otherwise `pc`<=next_pc, pulse `instr_retire`, and go to FETCH.
  - HALT: absorbing. Leave only via reset.
- **next_pc priority:**
  - `jump`=01: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - `jump`=10: `jr_target`.
  - Otherwise, branch taken (`branch[1]` && (`branch[0]` ? !`alu_zero` : `alu_zero`)): `pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
  - Otherwise: `pc_plus4`.
  - `jump` has priority over `branch` when both are active.
- **Arithmetic:** all PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 = 0, with no flag.
- **Traps** (evaluated in EXEC, only when `stall`=0):
  - `err_illegal_opcode` gives code 01.
  - `jump`=11 gives code 10.
  - A selected target with `[1:0]`!=0 gives code 11.
  - When several apply, the first one in this list wins.
- **On a trap:** `instr_retire` is not pulsed, `pc` keeps the faulting address, and `halted`/`err_code` set the next cycle.
- **Ack handling:** `imem_ack` outside FETCH is ignored. `imem_rdata` is ignored unless `imem_ack` is high.
- **Reset mid-operation:** from any state, the next cycle is IDLE with `pc`=`RESET_PC`. An outstanding request is dropped (`imem_req` low). An ack arriving during or after reset, before the new FETCH, is ignored.

## Timing
- **Reset values:**
  - `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4.
  - `instr`=0, so `opcode`=0 and `funct`=0.
  - `imem_req`=0, `instr_valid`=0, `instr_retire`=0, `halted`=0, `err_code`=00.
- `imem_req` rises in the first cycle after `rst_n` goes high (IDLE→FETCH).
- **Zero-wait memory:** `imem_ack` arrives in the same cycle as `imem_req`, giving 2 cycles per instruction (FETCH, EXEC). Each wait cycle adds 1.
- **Stall:** each stalled cycle adds 1 EXEC cycle. `instr`, `pc` and `instr_valid` stay stable throughout.
- Decoder outputs are combinational from `instr` and are sampled in the EXEC cycle that has `stall`=0.
- `instr_retire` is high exactly in that cycle, coincident with the `pc` update at the following edge.

## Configuration
- `FETCH_TRAP_EN`
  - **Defined:** trap behaviour as specified above.
  - **Undefined:**
    - No traps and `err_code` stays 00.
    - An illegal opcode or `jump`=11 retires with next_pc=`pc_plus4`.
    - Misaligned targets have bits [1:0] forced to 00.
    - HALT is unreachable and `halted` stays 0.

## Test plan
- **Reset/sequential fetch:** reset with `RESET_PC`=0, zero-wait ack, NOP stream → `imem_addr` 0, 4, 8, 12; one `instr_retire` every 2 cycles; `imem_req` low during reset.
- **Wait states and stall:** ack delayed 3 cycles, then `stall` for 2 EXEC cycles → `imem_addr` held for 4 cycles, `instr` held for 3 cycles, single `instr_retire`.
- **Branch/jump:**
  - `pc`=0x100, beq with imm=0xFFFF and `alu_zero`=1 → next `pc`=0x100.
  - bne with `alu_zero`=1 → 0x104.
  - j with target field 0x40 → 0x100.
  - jr with `jr_target`=0x2000 → 0x2000.
- **Priority and wrap:**
  - `jump`=01 and taken `branch` together → jump target.
  - `pc`=0xFFFF_FFFC, NOP → `pc`=0.
- **Traps (`FETCH_TRAP_EN`):**
  - `err_illegal_opcode`=1 → `halted`=1, `err_code`=01, `pc` unchanged, no further `imem_req`.
  - jr to 0x2002 → `err_code`=11.
  - With the macro undefined, jr to 0x2002 → `pc`=0x2000.
- **Reset mid-fetch:** drop `rst_n` while `imem_req`=1, ack during reset → `instr` stays 0, fetch restarts at `RESET_PC`.
